// File: rtl/pkt_axi_master.sv
// pkt_axi_master: single-outstanding AXI4 INCR burst master fed by a command port and data streams.
// Define PKT_AXI_MASTER_TIMEOUT_EN to build the stall watchdog that drives timeout_o.
module pkt_axi_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        done_o,
    output logic        resp_err_o,
    output logic        timeout_o,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        rerr_q, rerr_d;
    logic        done_q, done_d;
    logic        resp_err_q, resp_err_d;

    // Legal TIMEOUT_CYCLES range is 1..65535; nothing is built for it here.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            rerr_q     <= 1'b0;
            done_q     <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            rerr_q     <= rerr_d;
            done_q     <= done_d;
            resp_err_q <= resp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        rerr_d     = rerr_q;
        done_d     = 1'b0;
        resp_err_d = 1'b0;

        cmd_ready     = (state_q == S_IDLE);
        m_axi_awaddr  = addr_q;
        m_axi_awlen   = len_q;
        m_axi_awsize  = 3'b010;
        m_axi_awburst = 2'b01;
        m_axi_awvalid = (state_q == S_AW);
        m_axi_wdata   = wd_data;
        m_axi_wstrb   = '1;
        m_axi_wvalid  = (state_q == S_W) && wd_valid;
        m_axi_wlast   = (state_q == S_W) && (beat_q == len_q);
        wd_ready      = (state_q == S_W) && m_axi_wready;
        m_axi_bready  = (state_q == S_B);
        m_axi_araddr  = addr_q;
        m_axi_arlen   = len_q;
        m_axi_arsize  = 3'b010;
        m_axi_arburst = 2'b01;
        m_axi_arvalid = (state_q == S_AR);
        m_axi_rready  = (state_q == S_R) && rd_ready;
        rd_valid      = (state_q == S_R) && m_axi_rvalid;
        rd_data       = m_axi_rdata;
        rd_last       = (state_q == S_R) && m_axi_rlast;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    beat_d  = '0;
                    rerr_d  = 1'b0;
                    state_d = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                if (m_axi_awready) state_d = S_W;
            end
            S_W: begin
                if (wd_valid && m_axi_wready) begin
                    if (beat_q == len_q) begin
                        beat_d  = '0;
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    done_d     = 1'b1;
                    resp_err_d = (m_axi_bresp != 2'b00);
                    state_d    = S_IDLE;
                end
            end
            S_AR: begin
                if (m_axi_arready) state_d = S_R;
            end
            S_R: begin
                // rlast always ends the burst; a beat count that disagrees with len is reported as an error.
                if (m_axi_rvalid && rd_ready) begin
                    if (m_axi_rlast) begin
                        done_d     = 1'b1;
                        resp_err_d = rerr_q || (m_axi_rresp != 2'b00) || (beat_q != len_q);
                        beat_d     = '0;
                        state_d    = S_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        if ((m_axi_rresp != 2'b00) || (beat_q == len_q)) rerr_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign done_o     = done_q;
    assign resp_err_o = resp_err_q;

`ifdef PKT_AXI_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] stall_q, stall_d;
    logic        timeout_q, timeout_d;
    logic        progress;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        progress = (state_d != state_q)
                 || (m_axi_awvalid && m_axi_awready)
                 || (m_axi_wvalid && m_axi_wready)
                 || (m_axi_bvalid && m_axi_bready)
                 || (m_axi_arvalid && m_axi_arready)
                 || (m_axi_rvalid && m_axi_rready);
        stall_d   = stall_q;
        timeout_d = timeout_q;
        if ((state_q == S_IDLE) || progress) begin
            stall_d = '0;
        end else if (stall_q != '1) begin
            stall_d = stall_q + 16'd1;
        end
        if (stall_d >= TIMEOUT_LIMIT) timeout_d = 1'b1;
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_axi_master.sv
// Self-checking bench for pkt_axi_master: directed vector table, random bursts vs. a transaction-level
// model, mid-burst reset, and (with PKT_AXI_MASTER_TIMEOUT_EN) the watchdog.
module tb_pkt_axi_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done_o, resp_err_o, timeout_o;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    pkt_axi_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_o(done_o), .resp_err_o(resp_err_o), .timeout_o(timeout_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  resp;      // bresp for writes, rresp on err_beat for reads
        int          err_beat;  // -1: all read beats OKAY
        int          last_idx;  // read beat index carrying rlast
        int          stall;     // cycles awready/arready held low
        int          mode;      // 0 always ready, 1 random handshakes, 2 rd_ready toggles
        logic [31:0] data0;     // first read beat data
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: burst did not complete within the cycle budget (t=%0t)", name, $time);
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    endtask

    task automatic chk_common(input bit done_exp, input bit err_exp);
        chk("done_o", done_o, done_exp);
        chk("resp_err_o", resp_err_o, err_exp);
        chk("aw_ar_exclusive", m_axi_awvalid & m_axi_arvalid, 0);
`ifndef PKT_AXI_MASTER_TIMEOUT_EN
        chk("timeout_o_tied", timeout_o, 0);
`endif
    endtask

    task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len);
        @(negedge clk);
        idle_inputs();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        chk_common(0, 0);
        @(posedge clk);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bresp,
                             input int stall, input int mode, input bit exp_err);
        logic [31:0] wdat [256];
        int beats = 0;
        int n = 0;
        bit aw_done = 0, b_done = 0;
        bit awr, wv, wr, bv, exp_wv;
        for (int i = 0; i < 256; i++) wdat[i] = $urandom;
        issue_cmd(1'b1, addr, len);
        while (!b_done) begin
            if (n > 3000) begin fail_bound("write_burst"); break; end
            @(negedge clk);
            cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 8'($urandom);
            awr = (stall > 0) ? 1'b0 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
            wv  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            wr  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            bv  = (beats > int'(len)) && ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
            m_axi_awready = awr; wd_valid = wv; m_axi_wready = wr; m_axi_bvalid = bv;
            wd_data = (beats <= int'(len)) ? wdat[beats] : $urandom;
            m_axi_bresp = bv ? bresp : 2'($urandom);
            #1;
            chk("cmd_ready_busy", cmd_ready, 0);
            chk_common(0, 0);
            chk("awvalid", m_axi_awvalid, !aw_done);
            chk("arvalid_in_write", m_axi_arvalid, 0);
            if (!aw_done) begin
                chk("awaddr", m_axi_awaddr, addr);
                chk("awlen", m_axi_awlen, len);
                chk("awsize", m_axi_awsize, 3'b010);
                chk("awburst", m_axi_awburst, 2'b01);
            end
            exp_wv = aw_done && (beats <= int'(len)) && wv;
            chk("wvalid", m_axi_wvalid, exp_wv);
            chk("wd_ready", wd_ready, aw_done && (beats <= int'(len)) && wr);
            if (exp_wv) begin
                chk("wdata", m_axi_wdata, wdat[beats]);
                chk("wlast", m_axi_wlast, beats == int'(len));
                chk("wstrb", m_axi_wstrb, 4'hF);
            end
            chk("bready", m_axi_bready, aw_done && (beats > int'(len)));
            @(posedge clk);
            if (!aw_done && awr) aw_done = 1;
            else if (aw_done && (beats <= int'(len)) && wv && wr) beats++;
            else if ((beats > int'(len)) && bv) b_done = 1;
            stall--; n++; cyc++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk_common(1, exp_err);
        chk("cmd_ready_after_done", cmd_ready, 1);
        chk("bready_after_done", m_axi_bready, 0);
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input int last_idx,
                            input int err_beat, input logic [1:0] rresp, input int stall,
                            input int mode, input logic [31:0] data0, input bit exp_err);
        logic [31:0] rdat [256];
        int k = 0;
        int n = 0;
        bit ar_done = 0, fin = 0;
        bit arr, rv, rr;
        for (int i = 0; i < 256; i++) rdat[i] = $urandom;
        rdat[0] = data0;
        issue_cmd(1'b0, addr, len);
        while (!fin) begin
            if (n > 3000) begin fail_bound("read_burst"); break; end
            @(negedge clk);
            cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 8'($urandom);
            arr = (stall > 0) ? 1'b0 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
            rv  = ar_done && ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
            rr  = (mode == 0) ? 1'b1 : ((mode == 2) ? ((cyc % 2) == 1) : 1'($urandom_range(0, 1)));
            m_axi_arready = arr; m_axi_rvalid = rv; rd_ready = rr;
            m_axi_rdata = rdat[k];
            m_axi_rlast = (k == last_idx);
            m_axi_rresp = (k == err_beat) ? rresp : 2'b00;
            #1;
            chk("cmd_ready_busy", cmd_ready, 0);
            chk_common(0, 0);
            chk("arvalid", m_axi_arvalid, !ar_done);
            chk("awvalid_in_read", m_axi_awvalid, 0);
            chk("wvalid_in_read", m_axi_wvalid, 0);
            if (!ar_done) begin
                chk("araddr", m_axi_araddr, addr);
                chk("arlen", m_axi_arlen, len);
                chk("arsize", m_axi_arsize, 3'b010);
                chk("arburst", m_axi_arburst, 2'b01);
            end
            chk("rready", m_axi_rready, ar_done && rr);
            chk("rd_valid", rd_valid, rv);
            if (rv) begin
                chk("rd_data", rd_data, rdat[k]);
                chk("rd_last", rd_last, k == last_idx);
            end
            @(posedge clk);
            if (!ar_done && arr) ar_done = 1;
            else if (rv && rr) begin
                if (k == last_idx) fin = 1;
                k++;
            end
            stall--; n++; cyc++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk_common(1, exp_err);
        chk("cmd_ready_after_done", cmd_ready, 1);
    endtask

    // Transaction-level error rule for reads: any non-OKAY beat up to rlast, or rlast not on beat len.
    function automatic bit read_err_model(input int len, input int last_idx, input int err_beat);
        return (last_idx != len) || (err_beat >= 0 && err_beat <= last_idx);
    endfunction

    localparam int NVEC = 12;
    vec_t tbl [NVEC];

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_1000, 8'd3,   2'b00, -1, 0, 0,  0, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h0000_2000, 8'd0,   2'b00, -1, 0, 0,  0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_3000, 8'd1,   2'b10, -1, 0, 0,  0, 32'h0,         1'b1};
        tbl[3]  = '{1'b0, 32'h0000_4000, 8'd7,   2'b00, -1, 7, 0,  2, 32'h1234_5678, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_5000, 8'd0,   2'b00, -1, 0, 20, 0, 32'h0,         1'b0};
        tbl[5]  = '{1'b0, 32'h0000_6000, 8'd3,   2'b00, -1, 1, 0,  0, 32'hA5A5_0001, 1'b1};
        tbl[6]  = '{1'b0, 32'h0000_7000, 8'd2,   2'b00, -1, 4, 0,  0, 32'hA5A5_0002, 1'b1};
        tbl[7]  = '{1'b0, 32'h0000_8000, 8'd1,   2'b10, 0,  1, 0,  0, 32'hA5A5_0003, 1'b1};
        tbl[8]  = '{1'b1, 32'h0000_9000, 8'd255, 2'b00, -1, 0, 0,  1, 32'h0,         1'b0};
        tbl[9]  = '{1'b0, 32'h0000_A000, 8'd0,   2'b11, 0,  0, 0,  0, 32'hA5A5_0004, 1'b1};
        tbl[10] = '{1'b1, 32'h0000_B000, 8'd2,   2'b01, -1, 0, 3,  1, 32'h0,         1'b1};
        tbl[11] = '{1'b0, 32'h0000_C000, 8'd4,   2'b00, -1, 4, 2,  1, 32'hA5A5_0005, 1'b0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_awvalid", m_axi_awvalid, 0);
        chk("reset_wvalid", m_axi_wvalid, 0);
        chk("reset_bready", m_axi_bready, 0);
        chk("reset_arvalid", m_axi_arvalid, 0);
        chk("reset_rready", m_axi_rready, 0);
        chk("reset_timeout", timeout_o, 0);
        chk_common(0, 0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].wr)
                run_write(tbl[i].addr, tbl[i].len, tbl[i].resp, tbl[i].stall, tbl[i].mode, tbl[i].exp_err);
            else
                run_read(tbl[i].addr, tbl[i].len, tbl[i].last_idx, tbl[i].err_beat, tbl[i].resp,
                         tbl[i].stall, tbl[i].mode, tbl[i].data0, tbl[i].exp_err);
        end

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int len, li, eb;
            logic [1:0] rsp;
            a   = {$urandom, 2'b00};
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                run_write(a, 8'(len), rsp, $urandom_range(0, 3), 1, rsp != 2'b00);
            end else begin
                li  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 3) : len;
                eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, li + 1) : -1;
                rsp = 2'($urandom_range(1, 3));
                run_read(a, 8'(len), li, eb, rsp, $urandom_range(0, 3), 1, $urandom,
                         read_err_model(len, li, eb));
            end
        end

        // Reset during the W phase: burst dropped, no completion, beat counter restarted.
        issue_cmd(1'b1, 32'h0000_F000, 8'd3);
        @(negedge clk); cmd_valid = 1'b0; m_axi_awready = 1'b1;
        @(posedge clk);
        @(negedge clk); m_axi_awready = 1'b0; wd_valid = 1'b1; m_axi_wready = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0; idle_inputs();
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_wvalid", m_axi_wvalid, 0);
        chk("midrst_bready", m_axi_bready, 0);
        chk_common(0, 0);
        @(negedge clk);
        #1;
        chk_common(0, 0);
        run_write(32'h0000_F100, 8'd1, 2'b00, 0, 0, 1'b0);

`ifdef PKT_AXI_MASTER_TIMEOUT_EN
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        issue_cmd(1'b1, 32'h0000_E000, 8'd0);
        @(negedge clk); cmd_valid = 1'b0; m_axi_awready = 1'b1;
        @(posedge clk);
        @(negedge clk); m_axi_awready = 1'b0; wd_valid = 1'b1; m_axi_wready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk); idle_inputs();
            #1;
            chk("timeout_o_stall", timeout_o, c >= 17);
        end
        @(negedge clk); m_axi_bvalid = 1'b1;
        @(posedge clk);
        @(negedge clk); idle_inputs();
        #1;
        chk("timeout_done", done_o, 1);
        chk("timeout_sticky", timeout_o, 1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("timeout_cleared", timeout_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
